in_port_debounce: RTL and testbench

- Input port stage for the 4-bit TD4 CPU.
- Takes raw asynchronous switch inputs and synchronises them into the CLK domain.
- Debounces each bit independently.
- Presents a value that changes only on the CPU tick, so the data selector's IN operand is stable for a whole CPU instruction cycle.
- Sits directly upstream of the data selector's input-port leg. Runs on the board clock alongside the 1 Hz clock generator.

---
 rtl/in_port_debounce_if.sv | 27 ++
 rtl/in_port_debounce.sv | 67 ++++++
 tb/tb_in_port_debounce.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/in_port_debounce_if.sv
// Input-port bundle between the raw switch/tick sources and the debounce stage.
// The debounce stage is the slave; the switch/tick side is the master.
interface in_port_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pin;
  logic             cpu_tick;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] qd;
  logic             changed;

  modport master (
    output pin,
    output cpu_tick,
    input  stable,
    input  qd,
    input  changed
  );

  modport slave (
    input  pin,
    input  cpu_tick,
    output stable,
    output qd,
    output changed
  );
endinterface

// File: rtl/in_port_debounce.sv
// TD4 input port: two-flop synchroniser, per-bit debounce counters, and a
// CPU-tick-aligned holding register feeding the data selector's IN leg.
module in_port_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic               CLK,
  input logic               RST,
  in_port_debounce_if.slave bus
);
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_qd;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic             r_flipSeen;
  logic             r_changed;
  logic [WIDTH-1:0] w_flip;

  // A bit flips on the edge where it still disagrees and has already disagreed for the full window.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_flip[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_qd       <= '0;
      r_flipSeen <= 1'b0;
      r_changed  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= bus.pin;
      r_s2 <= r_s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      // The pulse lands one edge after the flip, so it is seen alongside the new stable value.
      r_flipSeen <= |w_flip;
      r_changed  <= r_flipSeen;
      if (bus.cpu_tick) begin
        r_qd <= r_stable;
      end
    end
  end

  assign bus.stable  = r_stable;
  assign bus.qd      = r_qd;
  assign bus.changed = r_changed;
endmodule

// File: tb/tb_in_port_debounce.sv
// Directed bench for in_port_debounce with DEBOUNCE_CYCLES=4: a vector table for
// reset release, plus hand sequences for glitch, bounce, tick alignment and async reset.
module tb_in_port_debounce;
  logic CLK;
  logic RST;
  int   compared;
  int   mismatched;

  in_port_debounce_if #(.WIDTH(4)) bus ();

  in_port_debounce #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] pinVal;
    logic       tick;
    logic [3:0] expStable;
    logic [3:0] expQd;
    logic       expChanged;
  } vec_t;

  vec_t vecs [12];

  // One call is one rising edge with the given inputs; returns 1 time unit after it.
  task automatic applyStimulus(input logic [3:0] pinVal, input logic tick);
    bus.pin      = pinVal;
    bus.cpu_tick = tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expS,
                             input logic [3:0] expQ, input logic expC);
    compared++;
    if (bus.stable !== expS) begin
      mismatched++;
      $display("[TB] FAIL %s stable: got %h, want %h", name, bus.stable, expS);
    end
    compared++;
    if (bus.qd !== expQ) begin
      mismatched++;
      $display("[TB] FAIL %s qd: got %h, want %h", name, bus.qd, expQ);
    end
    compared++;
    if (bus.changed !== expC) begin
      mismatched++;
      $display("[TB] FAIL %s changed: got %b, want %b", name, bus.changed, expC);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Leaves reset released between edges; the next applyStimulus is edge 1.
  task automatic resetDut();
    RST          = 1'b1;
    bus.pin      = 4'h0;
    bus.cpu_tick = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset state", 4'h0, 4'h0, 1'b0);
    RST = 1'b0;
  endtask

  initial begin
    int pulses;
    compared   = 0;
    mismatched = 0;
    RST        = 1'b1;
    bus.pin    = 4'h0;
    bus.cpu_tick = 1'b0;

    // Reset release with pin=F: first capture at edge 1, flip at 1+4+1=6, pulse at 7, tick at 10.
    vecs[0]  = '{4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[4]  = '{4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{4'hF, 1'b0, 4'hF, 4'h0, 1'b0};
    vecs[6]  = '{4'hF, 1'b0, 4'hF, 4'h0, 1'b1};
    vecs[7]  = '{4'hF, 1'b0, 4'hF, 4'h0, 1'b0};
    vecs[8]  = '{4'hF, 1'b0, 4'hF, 4'h0, 1'b0};
    vecs[9]  = '{4'hF, 1'b1, 4'hF, 4'hF, 1'b0};
    vecs[10] = '{4'hF, 1'b0, 4'hF, 4'hF, 1'b0};
    vecs[11] = '{4'hF, 1'b0, 4'hF, 4'hF, 1'b0};

    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].pinVal, vecs[i].tick);
      checkOutput($sformatf("release edge%0d", i + 1),
                  vecs[i].expStable, vecs[i].expQd, vecs[i].expChanged);
    end

    // Three-cycle pulse on bit 0 never completes the window.
    resetDut();
    for (int e = 1; e <= 12; e++) begin
      applyStimulus((e <= 3) ? 4'h1 : 4'h0, (e % 5) == 0);
      checkOutput($sformatf("glitch3 edge%0d", e), 4'h0, 4'h0, 1'b0);
    end

    // Four-cycle pulse on bit 0 just reaches the window: flip at edge 6.
    resetDut();
    for (int e = 1; e <= 7; e++) begin
      applyStimulus((e <= 4) ? 4'h1 : 4'h0, 1'b0);
      checkOutput($sformatf("glitch4 edge%0d", e), (e >= 6) ? 4'h1 : 4'h0,
                  4'h0, e == 7);
    end

    // Bounce on bit 2: settled high first captured at edge 5, flip at 5+4+1=10.
    resetDut();
    pulses = 0;
    for (int e = 1; e <= 14; e++) begin
      applyStimulus((e == 2 || e == 4) ? 4'h0 : 4'h4, 1'b0);
      if (bus.changed === 1'b1) pulses++;
      checkOutput($sformatf("bounce edge%0d", e), (e >= 10) ? 4'h4 : 4'h0,
                  4'h0, e == 11);
    end
    checkCount("bounce pulse count", pulses, 1);

    // Tick on the flip edge samples the old value; the next tick picks up 5.
    resetDut();
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(4'h5, (e == 6) || (e == 10));
      checkOutput($sformatf("tickalign edge%0d", e), (e >= 6) ? 4'h5 : 4'h0,
                  (e >= 10) ? 4'h5 : 4'h0, e == 7);
    end

    // Bits 3 and 1 together, tick held high so qd lags stable by one edge.
    resetDut();
    pulses = 0;
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(4'hA, 1'b1);
      if (bus.changed === 1'b1) pulses++;
      checkOutput($sformatf("simul edge%0d", e), (e >= 6) ? 4'hA : 4'h0,
                  (e >= 7) ? 4'hA : 4'h0, e == 7);
    end
    checkCount("simul pulse count", pulses, 1);

    // Async reset with bits 3/1 counting toward low (cnt=2 after edge 11).
    resetDut();
    for (int e = 1; e <= 11; e++) begin
      applyStimulus((e >= 8) ? 4'h5 : 4'hF, e == 7);
    end
    checkOutput("pre-async-reset", 4'hF, 4'hF, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async reset immediate", 4'h0, 4'h0, 1'b0);
    for (int e = 1; e <= 2; e++) begin
      applyStimulus(4'hF, 1'b1);
      checkOutput($sformatf("reset hold edge%0d", e), 4'h0, 4'h0, 1'b0);
    end
    #1;
    RST          = 1'b0;
    bus.cpu_tick = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(4'hF, e == 7);
      checkOutput($sformatf("post-reset edge%0d", e), (e >= 6) ? 4'hF : 4'h0,
                  (e >= 7) ? 4'hF : 4'h0, e == 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
